// File: rtl/mmu_defs.sv
`default_nettype none
// ============================================================================
// Module      : mmu_defs
// Description : Shared MMU definitions: TLB op codes, controller states,
//               TLB entry width and field bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_defs;

    localparam int c_ENTRY_W  = 80;
    localparam int c_ASID_MSB = 79;
    localparam int c_ASID_LSB = 72;
    localparam int c_G_BIT    = 71;
    localparam int c_VPN2_MSB = 70;
    localparam int c_VPN2_LSB = 52;
    localparam int c_LO1_MSB  = 51;
    localparam int c_LO1_LSB  = 26;
    localparam int c_LO0_MSB  = 25;
    localparam int c_LO0_LSB  = 0;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } tlb_state_t;

endpackage
`default_nettype wire

// File: rtl/tlb_random.sv
`default_nettype none
// ============================================================================
// Module      : tlb_random
// Description : CP0 Random register: free-running down-counter bounded below
//               by Wired, reloading to the top entry index.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_random #(
    parameter logic [3:0] TOP = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] wired,
    input  logic       wired_we,
    output logic [3:0] random
);

    logic [3:0] r_random;

    // random <= wired covers the wrap at Wired, a raised Wired, and Wired == TOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_random <= TOP;
        end else if (wired_we || (r_random <= wired)) begin
            r_random <= TOP;
        end else begin
            r_random <= r_random - 4'd1;
        end
    end

    assign random = r_random;

endmodule
`default_nettype wire

// File: rtl/tlb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ctrl
// Description : Sequencer for the CP0 TLB instructions TLBP/TLBR/TLBWI/TLBWR
//               driving the external entry array, probe and CP0 writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_ctrl
    import mmu_defs::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int ENTRY_W     = c_ENTRY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    output logic               op_done,
    input  logic [3:0]         cp0_index,
    input  logic [3:0]         cp0_wired,
    input  logic               cp0_wired_we,
    input  logic [ENTRY_W-1:0] cp0_entry,
    output logic               tlb_we,
    output logic [3:0]         tlb_widx,
    output logic [ENTRY_W-1:0] tlb_wdata,
    output logic [3:0]         tlb_ridx,
    input  logic [ENTRY_W-1:0] tlb_rdata,
    output logic [18:0]        probe_vpn2,
    output logic [7:0]         probe_asid,
    input  logic               probe_miss,
    input  logic [3:0]         probe_idx,
    output logic               index_we,
    output logic [31:0]        index_wdata,
    output logic               entry_we,
    output logic [ENTRY_W-1:0] entry_wdata,
    output logic [3:0]         random
);

    localparam logic [3:0] c_RAND_TOP = 4'(TLB_ENTRIES - 1);

    tlb_state_t         r_state;
    tlb_state_t         w_state_next;
    tlb_op_t            r_op;
    logic [ENTRY_W-1:0] r_entry;
    logic [ENTRY_W-1:0] r_rdata;
    logic               r_probe_miss;
    logic [3:0]         r_probe_idx;
    logic               w_accept;

    assign op_ready = (r_state == ST_IDLE);
    assign w_accept = op_valid && op_ready;

    tlb_random #(
        .TOP (c_RAND_TOP)
    ) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (cp0_wired),
        .wired_we (cp0_wired_we),
        .random   (random)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= OP_TLBP;
            r_entry      <= '0;
            r_rdata      <= '0;
            r_probe_miss <= 1'b0;
            r_probe_idx  <= 4'd0;
        end else begin
            if (w_accept) begin
                r_op    <= tlb_op_t'(op_code);
                r_entry <= cp0_entry;
            end
            if ((r_state == ST_EXEC) && (r_op == OP_TLBP)) begin
                r_probe_miss <= probe_miss;
                r_probe_idx  <= probe_idx;
            end
            if ((r_state == ST_EXEC) && (r_op == OP_TLBR)) begin
                r_rdata <= tlb_rdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        op_done      = 1'b0;
        tlb_we       = 1'b0;
        tlb_widx     = 4'd0;
        tlb_wdata    = '0;
        tlb_ridx     = 4'd0;
        probe_vpn2   = 19'd0;
        probe_asid   = 8'd0;
        index_we     = 1'b0;
        index_wdata  = 32'd0;
        entry_we     = 1'b0;
        entry_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_DONE;
                case (r_op)
                    OP_TLBWI: begin
                        tlb_we    = 1'b1;
                        tlb_widx  = cp0_index;
                        tlb_wdata = r_entry;
                    end
                    OP_TLBWR: begin
                        tlb_we    = 1'b1;
                        tlb_widx  = random;
                        tlb_wdata = r_entry;
                    end
                    OP_TLBP: begin
                        probe_vpn2 = r_entry[c_VPN2_MSB:c_VPN2_LSB];
                        probe_asid = r_entry[c_ASID_MSB:c_ASID_LSB];
                    end
                    default: begin
                        tlb_ridx = cp0_index;
                    end
                endcase
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                op_done      = 1'b1;
                if (r_op == OP_TLBP) begin
                    index_we    = 1'b1;
                    index_wdata = {r_probe_miss, 27'd0, r_probe_idx};
                end else if (r_op == OP_TLBR) begin
                    entry_we    = 1'b1;
                    entry_wdata = r_rdata;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 Parameter TLB_ENTRIES, default 16, number of TLB entries; index width is 4 bits.
REQ-002 Parameter ENTRY_W, default 80, width of one TLB entry {ASID[79:72], G[71], VPN2[70:52], PFN1/D1/V1[51:26], PFN0/D0/V0[25:0]}.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 op_valid  in  1  CP0 requests a TLB operation.
REQ-006 op_code  in  2  operation: 0 = TLBP, 1 = TLBR, 2 = TLBWI, 3 = TLBWR.
REQ-007 op_ready  out  1  controller can accept an operation.
REQ-008 op_done  out  1  one-cycle pulse when the operation completes.
REQ-009 cp0_index  in  4  Index register field, used by TLBWI and TLBR.
REQ-010 cp0_wired  in  4  Wired register value.
REQ-011 cp0_wired_we  in  1  CP0 is writing Wired this cycle.
REQ-012 cp0_entry  in  ENTRY_W  entry assembled from EntryHi/EntryLo0/EntryLo1.
REQ-013 tlb_we, tlb_widx[3:0], tlb_wdata[ENTRY_W-1:0]  out  write port to the TLB entry array.
REQ-014 tlb_ridx[3:0] out, tlb_rdata[ENTRY_W-1:0] in  combinational read port.
REQ-015 probe_vpn2[18:0], probe_asid[7:0] out; probe_miss in (1), probe_idx[3:0] in  combinational probe lookup.
REQ-016 index_we out (1), index_wdata out (32)  writeback to the CP0 Index register.
REQ-017 entry_we out (1), entry_wdata out (ENTRY_W)  writeback to EntryHi/Lo.
REQ-018 random  out  4  current Random register value.

Function
REQ-019 FSM states: IDLE, EXEC, DONE; op_ready = (state == IDLE).
REQ-020 An operation is accepted when op_valid && op_ready; op_code and cp0_entry are registered on acceptance, and the FSM goes IDLE -> EXEC.
REQ-021 EXEC -> DONE unconditionally; DONE -> IDLE unconditionally; op_done = 1 only in DONE, so latency is 2 cycles from acceptance to op_done.
REQ-022 TLBWI in EXEC: tlb_we = 1, tlb_widx = cp0_index, tlb_wdata = the registered entry, for exactly one cycle.
REQ-023 TLBWR in EXEC: the same, except tlb_widx = random sampled on the EXEC cycle.
REQ-024 TLBP in EXEC: probe_vpn2 and probe_asid are driven from the registered entry, and {probe_miss, probe_idx} is registered; in DONE: index_we = 1, index_wdata = {probe_miss, 27'b0, probe_idx}.
REQ-025 TLBR in EXEC: tlb_ridx = cp0_index and tlb_rdata is registered; in DONE: entry_we = 1, entry_wdata = that value.
REQ-026 At most one of tlb_we, index_we and entry_we is high in any cycle; all three are 0 outside the states named above.
REQ-027 op_valid while not in IDLE is ignored, not queued; the requester holds op_valid until op_ready.
REQ-028 random decrements by 1 every cycle; when random == cp0_wired it loads 15 on the next edge instead.
REQ-029 If cp0_wired == 15, random stays at 15.
REQ-030 If random < cp0_wired (Wired raised), random loads 15 on the next edge.
REQ-031 cp0_wired_we = 1 forces random to 15 on the next edge and takes priority over the decrement.
REQ-032 The random counter runs independently of the FSM, including while a TLBWR is in EXEC.
REQ-033 cp0_index and cp0_wired are used live, not captured; CP0 holds them stable while op_ready = 0.

Reset
REQ-034 While rst = 1: state = IDLE, random = 15, and op_done, tlb_we, index_we, entry_we, tlb_widx, tlb_ridx, index_wdata, entry_wdata, tlb_wdata, probe_vpn2 and probe_asid all = 0.
REQ-035 Reset asserted mid-operation aborts the operation with no write or writeback; after release op_ready = 1 on the first edge.

Structure
REQ-036 Op codes, state encodings, ENTRY_W and the field bit positions live in the shared mmu_defs package.
REQ-037 The Random counter is a sub-module tlb_random (clk, rst, wired, wired_we, random).
REQ-038 The entry array, probe logic and CP0 registers stay outside this block.

Verification
REQ-039 TLBWI with cp0_index = 5 and cp0_entry = 80'hA5 -> tlb_we for one cycle, idx 5, data 80'hA5 one cycle after acceptance; op_done the next cycle.
REQ-040 TLBP with probe returning miss = 0, idx = 9 -> index_wdata = 32'h0000_0009; with miss = 1 -> bit31 = 1; index_we is a single pulse.
REQ-041 cp0_wired = 3, free run -> random counts 15, 14, ..., 3, 15; cp0_wired_we at random = 8 -> next value 15; TLBWR writes the sampled random.
REQ-042 Back-to-back op_valid held high for TLBR then TLBWI -> second op accepted only on the cycle after op_done; entry_we precedes tlb_we, never overlapping.
REQ-043 rst asserted during EXEC of a TLBWI -> no tlb_we, all outputs 0, random = 15; normal operation resumes after release.
